// File: rtl/ahb_pkg.sv
// Shared AHB5-Lite encodings and the slave FSM state type for the SRAM subordinate.
package ahb_pkg;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonseq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } ahb_slv_state_t;

  // Unshifted lane mask covering the bytes of one transfer of the given size.
  function automatic logic [7:0] size_lanes(input logic [2:0] size);
    logic [7:0] lanes;
    lanes = 8'h00;
    unique case (size)
      HSIZE_BYTE:  lanes = 8'h01;
      HSIZE_HALF:  lanes = 8'h03;
      HSIZE_WORD:  lanes = 8'h0f;
      HSIZE_DWORD: lanes = 8'hff;
      default:     lanes = 8'h00;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// Byte-strobed register array: synchronous write port, asynchronous read port, no reset.
module ahb_slave_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 1024,
  localparam int unsigned StrbW     = DATA_WIDTH / 8,
  localparam int unsigned IdxW      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [IdxW-1:0]       addr_i,
  input  logic [StrbW-1:0]      strb_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < StrbW; b++) begin
        if (strb_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB5-Lite SRAM subordinate with configurable wait states and two-cycle ERROR responses.
// Define AHB_SLAVE_PROT_CHECK_EN to reject unprivileged writes (hprot[1] = 0).
module ahb_lite_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel_i,
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  input  logic [1:0]            htrans_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [2:0]            hburst_i,
  input  logic [3:0]            hprot_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  input  logic                  hready_i,
  output logic                  hreadyout_o,
  output logic                  hresp_o,
  output logic [DATA_WIDTH-1:0] hrdata_o
);

  localparam int unsigned     StrbW    = DATA_WIDTH / 8;
  localparam int unsigned     ByteIdxW = $clog2(StrbW);
  localparam int unsigned     IdxW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam longint unsigned MemBytes = 64'(MEM_DEPTH) * 64'(StrbW);

  ahb_slv_state_t        state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic                  priv_q, priv_d;

  logic                  ready_state, accept, addr_err, mem_we, unused_ok;
  logic [ADDR_WIDTH-1:0] off;
  logic [3:0]            align_mask;
  logic [IdxW-1:0]       word_idx;
  logic [StrbW-1:0]      strb;
  logic [DATA_WIDTH-1:0] rdata;

  // Only states that present hreadyout=1 can take a new address phase.
  assign ready_state = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
  assign accept      = ready_state && hsel_i && hready_i && htrans_i[1];
  assign off         = haddr_i - BASE_ADDR;
  assign align_mask  = (4'd1 << hsize_i) - 4'd1;

  always_comb begin
    addr_err = (haddr_i < BASE_ADDR) || (64'(off) >= MemBytes) ||
               (hsize_i > 3'(ByteIdxW)) || ((4'(haddr_i[2:0]) & align_mask) != 4'd0);
`ifdef AHB_SLAVE_PROT_CHECK_EN
    if (hwrite_i && !hprot_i[1]) begin
      addr_err = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    priv_d  = priv_q;
    unique case (state_q)
      StWait: begin
        if (wcnt_q <= 4'd1) begin
          state_d = StData;
          wcnt_d  = 4'd0;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      StErr1: state_d = StErr2;
      default: begin
        state_d = StIdle;
        if (accept) begin
          addr_d  = haddr_i;
          write_d = hwrite_i;
          size_d  = hsize_i;
`ifdef AHB_SLAVE_PROT_CHECK_EN
          priv_d  = hprot_i[1];
`else
          priv_d  = 1'b1;
`endif
          if (addr_err) begin
            state_d = StErr1;
          end else if (WAIT_STATES != 0) begin
            state_d = StWait;
            wcnt_d  = 4'(WAIT_STATES);
          end else begin
            state_d = StData;
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= StIdle;
      wcnt_q  <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
      priv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      priv_q  <= priv_d;
    end
  end

  always_comb begin
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    unique case (state_q)
      StWait: hreadyout_o = 1'b0;
      StErr1: begin
        hreadyout_o = 1'b0;
        hresp_o     = HRESP_ERROR;
      end
      StErr2:  hresp_o = HRESP_ERROR;
      default: ;
    endcase
  end

  assign word_idx = IdxW'((addr_q - BASE_ADDR) >> ByteIdxW);
  assign strb     = StrbW'({8'h00, size_lanes(size_q)} << addr_q[ByteIdxW-1:0]);
  // Privilege is re-checked on the registered copy so a dropped error can never write.
  assign mem_we   = (state_q == StData) && write_q && priv_q;
  assign hrdata_o = (state_q == StData) ? rdata : '0;

  ahb_slave_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_mem (
    .clk_i  (hclk),
    .we_i   (mem_we),
    .addr_i (word_idx),
    .strb_i (strb),
    .wdata_i(hwdata_i),
    .rdata_o(rdata)
  );

`ifdef AHB_SLAVE_PROT_CHECK_EN
  assign unused_ok = ^{hburst_i, htrans_i[0], hprot_i[3:2], hprot_i[0]};
`else
  assign unused_ok = ^{hburst_i, htrans_i[0], hprot_i};
`endif

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Bench for ahb_lite_sram_slave: two instances (0 and 3 wait states) checked against a byte-array model.
module tb_ahb_lite_sram_slave;
  import ahb_pkg::*;

  localparam int unsigned MemWords = 64;
  localparam int unsigned MemBytes = MemWords * 4;
  localparam logic [31:0] Base     = 32'h0000_0400;
`ifdef AHB_SLAVE_PROT_CHECK_EN
  localparam bit ProtEn = 1'b1;
`else
  localparam bit ProtEn = 1'b0;
`endif

  logic        hclk = 1'b0;
  logic        hresetn   [2];
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [2:0]  hburst    [2];
  logic [3:0]  hprot     [2];
  logic [31:0] hwdata    [2];
  logic        hready    [2];
  logic        hreadyout [2];
  logic        hresp     [2];
  logic [31:0] hrdata    [2];

  always #5 hclk = ~hclk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign hready[g] = hreadyout[g];
    ahb_lite_sram_slave #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .MEM_DEPTH  (MemWords),
      .BASE_ADDR  (Base),
      .WAIT_STATES((g == 0) ? 0 : 3)
    ) u_dut (
      .hclk       (hclk),
      .hresetn    (hresetn[g]),
      .hsel_i     (hsel[g]),
      .haddr_i    (haddr[g]),
      .htrans_i   (htrans[g]),
      .hwrite_i   (hwrite[g]),
      .hsize_i    (hsize[g]),
      .hburst_i   (hburst[g]),
      .hprot_i    (hprot[g]),
      .hwdata_i   (hwdata[g]),
      .hready_i   (hready[g]),
      .hreadyout_o(hreadyout[g]),
      .hresp_o    (hresp[g]),
      .hrdata_o   (hrdata[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned ws(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [3:0]  prot;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        acc;
    logic        err;
    logic [31:0] rexp;
  } tr_t;

  tr_t        tq[$];
  logic [7:0] ref_mem [2][MemBytes];

  // Reference model: transfers complete in issue order, so expectations are settled at push time.
  task automatic push(input int d, input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [3:0] prot, input logic [31:0] addr,
                      input logic [31:0] wdata);
    tr_t t;
    int unsigned w0, lane;
    t.sel = sel; t.trans = trans; t.wr = wr; t.size = size; t.prot = prot;
    t.addr = addr; t.wdata = wdata; t.err = 1'b0; t.rexp = 32'h0;
    t.acc = sel && trans[1];
    if (t.acc) begin
      t.err = (addr < Base) || (addr >= Base + MemBytes) || (size > 3'd2) ||
              (ProtEn && wr && !prot[1]);
      if (!t.err) t.err = (addr % (32'd1 << size)) != 0;
      if (!t.err) begin
        w0 = (addr - Base) & ~32'd3;
        if (wr) begin
          for (int b = 0; b < (1 << size); b++) begin
            lane = (addr % 4) + b;
            ref_mem[d][w0 + lane] = wdata[8*lane +: 8];
          end
        end else begin
          for (int b = 0; b < 4; b++) t.rexp[8*b +: 8] = ref_mem[d][w0 + b];
        end
      end
    end
    tq.push_back(t);
  endtask

  task automatic push_rand(input int d);
    logic        sel, wr;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [31:0] addr;
    int unsigned r;
    sel   = ($urandom_range(0, 19) != 0);
    trans = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
    size  = ($urandom_range(0, 19) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
    wr    = 1'($urandom_range(0, 1));
    r     = $urandom_range(0, 99);
    if (r < 4)       addr = Base - 32'($urandom_range(1, 16));
    else if (r < 8)  addr = Base + MemBytes + 32'($urandom_range(0, 31));
    else if (r < 20) addr = Base + 32'($urandom_range(0, MemBytes - 1));
    else             addr = Base + (32'($urandom_range(0, MemBytes - 1)) & ~((32'd1 << size) - 1));
    push(d, sel, trans, wr, size, 4'($urandom), addr, $urandom);
  endtask

  // Drives tq as a pipelined stream with hready looped back; checks every cycle's outputs.
  task automatic run(input int d, input string tag);
    int   ai = 0, di = -1, low = 0, guard = 0, n;
    logic rdy;
    n = tq.size();
    while ((ai < n || di >= 0) && guard < 5000) begin
      guard++;
      if (ai < n) begin
        hsel[d] = tq[ai].sel; htrans[d] = tq[ai].trans; hwrite[d] = tq[ai].wr;
        hsize[d] = tq[ai].size; hprot[d] = tq[ai].prot; haddr[d] = tq[ai].addr;
      end else begin
        hsel[d] = 1'b0; htrans[d] = HtransIdle;
      end
      hwdata[d] = (di >= 0) ? tq[di].wdata : 32'h0;
      @(negedge hclk);
      rdy = hreadyout[d];
      if (di < 0) begin
        check({tag, " idle hreadyout"}, 32'(rdy), 32'd1);
        check({tag, " idle hresp"}, 32'(hresp[d]), 32'd0);
        check({tag, " idle hrdata"}, hrdata[d], 32'h0);
      end else if (!rdy) begin
        low++;
        check({tag, " stall hresp"}, 32'(hresp[d]), 32'(tq[di].err));
        check({tag, " stall hrdata"}, hrdata[d], 32'h0);
      end else begin
        check({tag, " stall cycles"}, 32'(low), tq[di].err ? 32'd1 : 32'(ws(d)));
        check({tag, " hresp"}, 32'(hresp[d]), 32'(tq[di].err));
        if (tq[di].err) check({tag, " err hrdata"}, hrdata[d], 32'h0);
        else if (!tq[di].wr) check({tag, " hrdata"}, hrdata[d], tq[di].rexp);
      end
      @(posedge hclk);
      #1;
      if (rdy) begin
        if (ai < n) begin
          di = tq[ai].acc ? ai : -1;
          ai++;
        end else begin
          di = -1;
        end
        low = 0;
      end
    end
    if (guard >= 5000) begin
      checks++;
      errors++;
      $error("FAIL %s timeout: observed %0d cycles required completion", tag, guard);
    end
    hsel[d] = 1'b0;
    htrans[d] = HtransIdle;
    tq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish required finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      hresetn[d] = 1'b0; hsel[d] = 1'b0; haddr[d] = 32'h0; htrans[d] = HtransIdle;
      hwrite[d] = 1'b0; hsize[d] = HSIZE_WORD; hburst[d] = 3'b001; hprot[d] = 4'b0011;
      hwdata[d] = 32'h0;
    end
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      check("reset hreadyout", 32'(hreadyout[d]), 32'd1);
      check("reset hresp", 32'(hresp[d]), 32'd0);
      check("reset hrdata", hrdata[d], 32'h0);
      hresetn[d] = 1'b1;
    end
    @(posedge hclk);
    #1;

    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < MemWords; w++)
        push(d, 1'b1, (w == 0) ? HtransNonseq : HtransSeq, 1'b1, HSIZE_WORD, 4'b0011,
             Base + 32'(4 * w), $urandom);
      run(d, "fill");
    end

    push(0, 1'b1, HtransNonseq, 1'b1, HSIZE_WORD, 4'b0011, Base + 32'h10, 32'hDEADBEEF);
    push(0, 1'b1, HtransNonseq, 1'b0, HSIZE_WORD, 4'b0011, Base + 32'h10, 32'h0);
    run(0, "word round trip");

    push(0, 1'b1, HtransNonseq, 1'b1, HSIZE_WORD, 4'b0011, Base + 32'h20, 32'h11223344);
    push(0, 1'b1, HtransNonseq, 1'b1, HSIZE_BYTE, 4'b0011, Base + 32'h21, 32'h0000AA00);
    push(0, 1'b1, HtransNonseq, 1'b0, HSIZE_WORD, 4'b0011, Base + 32'h20, 32'h0);
    run(0, "byte lanes");

    push(0, 1'b1, HtransNonseq, 1'b0, HSIZE_WORD, 4'b0011, Base + MemBytes, 32'h0);
    push(0, 1'b1, HtransNonseq, 1'b0, HSIZE_WORD, 4'b0011, Base + 32'h10, 32'h0);
    push(0, 1'b1, HtransNonseq, 1'b1, HSIZE_HALF, 4'b0011, Base + 32'h3, 32'hFFFF_FFFF);
    push(0, 1'b1, HtransNonseq, 1'b0, HSIZE_WORD, 4'b0011, Base + 32'h0, 32'h0);
    run(0, "errors");

    for (int i = 0; i < 4; i++)
      push(0, 1'b1, (i == 0) ? HtransNonseq : HtransSeq, 1'b1, HSIZE_WORD, 4'b0011,
           Base + 32'h40 + 32'(4 * i), 32'(i + 1));
    for (int i = 0; i < 4; i++)
      push(0, 1'b1, (i == 0) ? HtransNonseq : HtransSeq, 1'b0, HSIZE_WORD, 4'b0011,
           Base + 32'h40 + 32'(4 * i), 32'h0);
    run(0, "burst");

    push(0, 1'b1, HtransNonseq, 1'b1, HSIZE_WORD, 4'b0001, Base + 32'h50, 32'h5555AAAA);
    push(0, 1'b1, HtransNonseq, 1'b0, HSIZE_WORD, 4'b0011, Base + 32'h50, 32'h0);
    run(0, "protection");

    for (int k = 0; k < 300; k++) push_rand(0);
    run(0, "random w0");

    push(1, 1'b1, HtransNonseq, 1'b0, HSIZE_WORD, 4'b0011, Base, 32'h0);
    push(1, 1'b1, HtransNonseq, 1'b1, HSIZE_WORD, 4'b0011, Base + 32'h8, 32'h0BADF00D);
    push(1, 1'b1, HtransNonseq, 1'b0, HSIZE_WORD, 4'b0011, Base + 32'h8, 32'h0);
    run(1, "wait states");

    for (int k = 0; k < 120; k++) push_rand(1);
    run(1, "random w3");

    // Write accepted, then reset lands in its wait phase: the write must be dropped.
    hsel[1] = 1'b1; htrans[1] = HtransNonseq; hwrite[1] = 1'b1; hsize[1] = HSIZE_WORD;
    hprot[1] = 4'b0011; haddr[1] = Base + 32'h30;
    @(posedge hclk);
    #1;
    hsel[1] = 1'b0; htrans[1] = HtransIdle; hwdata[1] = 32'hCAFEF00D;
    @(negedge hclk);
    check("reset mid wait stalled", 32'(hreadyout[1]), 32'd0);
    hresetn[1] = 1'b0;
    #1;
    check("reset mid wait hreadyout", 32'(hreadyout[1]), 32'd1);
    check("reset mid wait hresp", 32'(hresp[1]), 32'd0);
    check("reset mid wait hrdata", hrdata[1], 32'h0);
    @(posedge hclk);
    #1;
    hresetn[1] = 1'b1;
    @(posedge hclk);
    #1;
    push(1, 1'b1, HtransNonseq, 1'b0, HSIZE_WORD, 4'b0011, Base + 32'h30, 32'h0);
    run(1, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
